bit_serial_adder: RTL and testbench



---
 rtl/bit_serial_adder_pkg.sv | 19 +
 rtl/serial_fa_cell.sv | 13 +
 rtl/bit_serial_adder.sv | 95 +++++++++
 tb/tb_bit_serial_adder.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/bit_serial_adder_pkg.sv
// Shared state encodings and counter-sizing helper for the bit-serial adder.
package bit_serial_adder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned res;
    res = 0;
    for (int i = 0; i < 32; i++) begin
      if ((32'd1 << i) < value) res = i + 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/serial_fa_cell.sv
// Purely combinational one-bit full adder used as the serial datapath slice.
module serial_fa_cell (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ c;
  assign co = (a & b) | (a & c) | (b & c);

endmodule

// File: rtl/bit_serial_adder.sv
// LSB-first bit-serial adder: one full-adder slice plus a carry flop, WIDTH cycles per add.
module bit_serial_adder
  import bit_serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum_out,
  output logic             cout
);

  localparam int unsigned CNT_W = clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_e           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  // Only the upper WIDTH-1 partial-sum bits survive to the next cycle.
  logic [WIDTH-2:0] sum_sh;
  logic             carry;
  logic [CNT_W-1:0] cnt;
  logic             fa_s;
  logic             fa_co;
  logic [WIDTH-1:0] sum_next;

  serial_fa_cell u_fa (
    .a  (a_sh[0]),
    .b  (b_sh[0]),
    .c  (carry),
    .s  (fa_s),
    .co (fa_co)
  );

  assign sum_next = {fa_s, sum_sh};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      a_sh    <= '0;
      b_sh    <= '0;
      sum_sh  <= '0;
      carry   <= 1'b0;
      cnt     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      sum_out <= '0;
      cout    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            a_sh  <= a_in;
            b_sh  <= b_in;
            carry <= cin;
            cnt   <= '0;
            state <= ST_RUN;
            busy  <= 1'b1;
          end
        end
        ST_RUN: begin
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          sum_sh <= sum_next[WIDTH-1:1];
          carry  <= fa_co;
          if (cnt == CNT_LAST) begin
            sum_out <= sum_next;
            cout    <= fa_co;
            state   <= ST_DONE;
            done    <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bit_serial_adder.sv
// Self-checking bench: vector table plus hand-written corner sequences, scoreboard on done.
module tb_bit_serial_adder;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] a_in;
  logic [7:0] b_in;
  logic       cin;
  logic       busy;
  logic       done;
  logic [7:0] sum_out;
  logic       cout;

  bit_serial_adder #(.WIDTH(8)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .a_in    (a_in),
    .b_in    (b_in),
    .cin     (cin),
    .busy    (busy),
    .done    (done),
    .sum_out (sum_out),
    .cout    (cout)
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       ci;
    logic [7:0] s;
    logic       co;
  } vec_t;

  vec_t       vecs[8];
  logic [8:0] exp_q[$];
  logic [8:0] exp_v;
  int         n_checks = 0;
  int         n_fail = 0;
  int         done_seen = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard: every done pulse pops one expected {cout, sum_out}.
  always @(negedge clk) begin
    if (rst_n && done) begin
      done_seen++;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_done: actual done=1 sum=0x%0h required no done", sum_out);
      end else begin
        exp_v = exp_q.pop_front();
        check("result", {23'd0, cout, sum_out}, {23'd0, exp_v});
      end
    end
  end

  // One complete operation from IDLE; reports done latency and busy-cycle count.
  task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic ci,
                       input logic [7:0] s, input logic co, output int lat, output int busy_n);
    @(negedge clk);
    a_in  = a;
    b_in  = b;
    cin   = ci;
    start = 1'b1;
    exp_q.push_back({co, s});
    @(posedge clk);
    #1 start = 1'b0;
    a_in = '0;
    b_in = '0;
    cin  = 1'b0;
    lat    = -1;
    busy_n = 0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (busy) busy_n++;
      if (done && lat < 0) lat = i - 1;
    end
  endtask

  initial begin
    int lat;
    int busy_n;
    int d0;
    int hits;
    bit got;

    #200000;
    $display("FAIL timeout: actual simulation still running required finish");
    $fatal(1, "timeout");
  end

  initial begin
    int lat;
    int busy_n;
    int d0;
    int hits;
    bit got;

    vecs[0] = '{a: 8'h5A, b: 8'h3C, ci: 1'b0, s: 8'h96, co: 1'b0};
    vecs[1] = '{a: 8'hFF, b: 8'h01, ci: 1'b0, s: 8'h00, co: 1'b1};
    vecs[2] = '{a: 8'hFF, b: 8'hFF, ci: 1'b1, s: 8'hFF, co: 1'b1};
    vecs[3] = '{a: 8'h00, b: 8'h00, ci: 1'b1, s: 8'h01, co: 1'b0};
    vecs[4] = '{a: 8'hAA, b: 8'h55, ci: 1'b0, s: 8'hFF, co: 1'b0};
    vecs[5] = '{a: 8'h12, b: 8'h34, ci: 1'b1, s: 8'h47, co: 1'b0};
    vecs[6] = '{a: 8'h80, b: 8'h80, ci: 1'b0, s: 8'h00, co: 1'b1};
    vecs[7] = '{a: 8'hC3, b: 8'h7E, ci: 1'b1, s: 8'h42, co: 1'b1};

    rst_n = 1'b0;
    start = 1'b0;
    a_in  = '0;
    b_in  = '0;
    cin   = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_sum", {24'd0, sum_out}, 32'd0);
    check("reset_cout", {31'd0, cout}, 32'd0);
    rst_n = 1'b1;

    for (int v = 0; v < 8; v++) begin
      do_op(vecs[v].a, vecs[v].b, vecs[v].ci, vecs[v].s, vecs[v].co, lat, busy_n);
      check("latency", lat, 32'd8);
      check("busy_cycles", busy_n, 32'd9);
    end

    // Starts during RUN and DONE must be ignored.
    d0 = done_seen;
    got = 1'b0;
    @(negedge clk);
    a_in = 8'h10;
    b_in = 8'h01;
    cin = 1'b0;
    start = 1'b1;
    exp_q.push_back({1'b0, 8'h11});
    @(posedge clk);
    #1 start = 1'b0;
    repeat (2) @(negedge clk);
    a_in = 8'hAA;
    b_in = 8'h55;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (done) begin
        start = 1'b1;
        got = 1'b1;
        break;
      end
    end
    @(negedge clk);
    start = 1'b0;
    repeat (12) @(negedge clk);
    check("ignore_done_seen", {31'd0, got}, 32'd1);
    check("ignore_done_count", done_seen - d0, 32'd1);
    check("ignore_idle", {31'd0, busy}, 32'd0);

    // Operands scrambled every cycle during RUN.
    d0 = done_seen;
    @(negedge clk);
    a_in = 8'h80;
    b_in = 8'h80;
    cin = 1'b0;
    start = 1'b1;
    exp_q.push_back({1'b1, 8'h00});
    @(posedge clk);
    #1 start = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      a_in = 8'($urandom);
      b_in = 8'($urandom);
      cin  = 1'($urandom);
    end
    a_in = '0;
    b_in = '0;
    cin  = 1'b0;
    check("scramble_done_count", done_seen - d0, 32'd1);

    // Asynchronous reset mid-RUN discards the operation.
    do_op(8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, lat, busy_n);
    check("pre_reset_sum", {24'd0, sum_out}, 32'h96);
    @(negedge clk);
    a_in = 8'h33;
    b_in = 8'h44;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_busy", {31'd0, busy}, 32'd0);
    check("async_rst_done", {31'd0, done}, 32'd0);
    check("async_rst_sum", {24'd0, sum_out}, 32'd0);
    check("async_rst_cout", {31'd0, cout}, 32'd0);
    d0 = done_seen;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    check("no_done_after_reset", done_seen - d0, 32'd0);
    do_op(8'h01, 8'h02, 1'b0, 8'h03, 1'b0, lat, busy_n);
    check("post_reset_latency", lat, 32'd8);

    // start held high: re-trigger every WIDTH+2 cycles.
    hits = 0;
    repeat (3) exp_q.push_back({1'b0, 8'h10});
    @(negedge clk);
    a_in = 8'h07;
    b_in = 8'h09;
    cin = 1'b0;
    start = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (done) begin
        hits++;
        check("hold_phase", i % 10, 32'd8);
      end
    end
    start = 1'b0;
    repeat (12) @(negedge clk);
    check("hold_done_count", hits, 32'd3);
    check("scoreboard_empty", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
